serial_magnitude_comparator: RTL and testbench



---
 rtl/serial_magnitude_comparator_if.sv | 23 ++
 rtl/serial_magnitude_comparator.sv | 110 +++++++++++
 tb/tb_serial_magnitude_comparator.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_magnitude_comparator_if.sv
// rtl/serial_magnitude_comparator_if.sv - start/busy/done handshake, operands and result flags
interface serial_magnitude_comparator_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic             AGB;
   logic             AEB;
   logic             ALB;

   modport master (
      output start, A, B,
      input  busy, done, AGB, AEB, ALB
   );

   modport slave (
      input  start, A, B,
      output busy, done, AGB, AEB, ALB
   );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - LSB-first bit-serial A/B magnitude comparator
// Optional macro SERCMP_SIGNED_EN selects two's-complement comparison.
module serial_magnitude_comparator #(
   parameter int WIDTH = 8
) (
   input logic                          clk,
   input logic                          rst_n,
   serial_magnitude_comparator_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sa_q;
   logic [WIDTH-1:0] sb_q;
   logic [CW-1:0]    cnt_q;
   logic             gt_q;
   logic             lt_q;
   logic             busy_q;
   logic             done_q;
   logic             agb_q;
   logic             aeb_q;
   logic             alb_q;

   logic             last_bit;
   logic             bit_a;
   logic             bit_b;
   logic             gt_d;
   logic             lt_d;

   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   // The last differing bit wins, so later (more significant) bits overwrite the flags.
   always_comb begin
      bit_a = sa_q[0];
      bit_b = sb_q[0];
`ifdef SERCMP_SIGNED_EN
      if (last_bit) begin
         bit_a = sb_q[0];
         bit_b = sa_q[0];
      end
`endif
      gt_d = gt_q;
      lt_d = lt_q;
      if (bit_a && !bit_b) begin
         gt_d = 1'b1;
         lt_d = 1'b0;
      end else if (!bit_a && bit_b) begin
         gt_d = 1'b0;
         lt_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         cnt_q   <= '0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         agb_q   <= 1'b0;
         aeb_q   <= 1'b0;
         alb_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  sa_q    <= bus.A;
                  sb_q    <= bus.B;
                  gt_q    <= 1'b0;
                  lt_q    <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               gt_q  <= gt_d;
               lt_q  <= lt_d;
               sa_q  <= sa_q >> 1;
               sb_q  <= sb_q >> 1;
               cnt_q <= cnt_q + CW'(1);
               if (last_bit) begin
                  agb_q   <= gt_d;
                  alb_q   <= lt_d;
                  aeb_q   <= ~(gt_d | lt_d);
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.AGB  = agb_q;
   assign bus.AEB  = aeb_q;
   assign bus.ALB  = alb_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - self-checking bench for serial_magnitude_comparator
module tb_serial_magnitude_comparator;
   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   serial_magnitude_comparator_if #(.WIDTH(W)) bus ();

   serial_magnitude_comparator #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {AGB, AEB, ALB} from plain arithmetic on the operands.
   function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERCMP_SIGNED_EN
      if ($signed(a) > $signed(b)) return 3'b100;
      if ($signed(a) < $signed(b)) return 3'b001;
`else
      if (a > b) return 3'b100;
      if (a < b) return 3'b001;
`endif
      return 3'b010;
   endfunction

   function automatic logic [2:0] flags();
      return {bus.AGB, bus.AEB, bus.ALB};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one start and runs until done; lat counts edges from acceptance to done.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cnt);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      tick();
      bus.start = 1'b0;
      lat       = 0;
      busy_cnt  = bus.busy ? 1 : 0;
      while (!bus.done && lat < 4 * W) begin
         bus.A = W'($urandom);
         bus.B = W'($urandom);
         tick();
         lat++;
         if (bus.busy) busy_cnt++;
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({bus.busy, bus.done, flags()} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_idle cycle %0d: busy,done,AGB,AEB,ALB=%b required 00000",
                     i, {bus.busy, bus.done, flags()});
         end
         tick();
      end
   endtask

   task automatic test_basic();
      logic [W-1:0] va [3];
      logic [W-1:0] vb [3];
      int lat, bc;
      va = '{8'h5A, 8'h01, 8'hF0};
      vb = '{8'h5A, 8'h02, 8'h0F};
      for (int i = 0; i < 3; i++) begin
         run_op(va[i], vb[i], lat, bc);
         n_checks++;
         if (lat !== W || bc !== W) begin
            n_fail++;
            $display("FAIL basic_timing %h/%h: latency %0d busy %0d required %0d",
                     va[i], vb[i], lat, bc, W);
         end
         n_checks++;
         if (flags() !== model(va[i], vb[i])) begin
            n_fail++;
            $display("FAIL basic_flags %h/%h: got %b required %b",
                     va[i], vb[i], flags(), model(va[i], vb[i]));
         end
         tick();
         n_checks++;
         if (bus.done !== 1'b0 || flags() !== model(va[i], vb[i])) begin
            n_fail++;
            $display("FAIL basic_hold %h/%h: done %b flags %b required done 0 flags %b",
                     va[i], vb[i], bus.done, flags(), model(va[i], vb[i]));
         end
      end
   endtask

   task automatic test_signedness();
      int lat, bc;
      logic [2:0] req;
`ifdef SERCMP_SIGNED_EN
      req = 3'b001;
`else
      req = 3'b100;
`endif
      run_op(8'h80, 8'h7F, lat, bc);
      n_checks++;
      if (flags() !== req) begin
         n_fail++;
         $display("FAIL sign_80_7f: got %b required %b", flags(), req);
      end
      run_op(8'hFF, 8'hFE, lat, bc);
      n_checks++;
      if (flags() !== 3'b100) begin
         n_fail++;
         $display("FAIL sign_ff_fe: got %b required 100", flags());
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      int lat, bc;
      for (int i = 0; i < 40; i++) begin
         a = W'($urandom);
         b = (i % 5 == 0) ? a : W'($urandom);
         if (i % 7 == 3) b = a ^ W'(1 << $urandom_range(W - 1, 0));
         run_op(a, b, lat, bc);
         n_checks++;
         if (lat !== W || flags() !== model(a, b)) begin
            n_fail++;
            $display("FAIL random %h/%h: latency %0d flags %b required latency %0d flags %b",
                     a, b, lat, flags(), W, model(a, b));
         end
      end
   endtask

   task automatic test_ignore_busy();
      int lat, dones;
      bus.start = 1'b1;
      bus.A     = 8'h10;
      bus.B     = 8'h20;
      tick();
      bus.start = 1'b0;
      lat       = 0;
      while (!bus.done && lat < 4 * W) begin
         bus.start = (lat == 2);
         bus.A     = 8'h30;
         bus.B     = 8'h00;
         tick();
         lat++;
      end
      bus.start = 1'b0;
      n_checks++;
      if (lat !== W || flags() !== 3'b001) begin
         n_fail++;
         $display("FAIL ignore_busy: latency %0d flags %b required latency %0d flags 001",
                  lat, flags(), W);
      end
      dones = 0;
      for (int i = 0; i < 2 * W; i++) begin
         tick();
         if (bus.done || bus.busy) dones++;
      end
      n_checks++;
      if (dones !== 0) begin
         n_fail++;
         $display("FAIL ignore_busy_no_second: %0d busy/done cycles required 0", dones);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bc, held_bad;
      run_op(8'h04, 8'h03, lat, bc);
      n_checks++;
      if (flags() !== 3'b100) begin
         n_fail++;
         $display("FAIL b2b_first: got %b required 100", flags());
      end
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_busy_in_done: busy %b required 0", bus.busy);
      end
      bus.start = 1'b1;
      bus.A     = 8'h03;
      bus.B     = 8'h03;
      tick();
      bus.start = 1'b0;
      lat       = 0;
      held_bad  = 0;
      while (!bus.done && lat < 4 * W) begin
         if (bus.AGB !== 1'b1) held_bad++;
         tick();
         lat++;
      end
      n_checks++;
      if (lat !== W || flags() !== 3'b010) begin
         n_fail++;
         $display("FAIL b2b_second: latency %0d flags %b required latency %0d flags 010",
                  lat, flags(), W);
      end
      n_checks++;
      if (held_bad !== 0) begin
         n_fail++;
         $display("FAIL b2b_hold: AGB dropped in %0d cycles required 0", held_bad);
      end
   endtask

   task automatic test_reset_mid();
      int lat, bc, seen;
      bus.start = 1'b1;
      bus.A     = 8'hAA;
      bus.B     = 8'h55;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      rst_n = 1'b0;
      tick();
      n_checks++;
      if ({bus.busy, bus.done, flags()} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_mid_clear: busy,done,flags=%b required 00000",
                  {bus.busy, bus.done, flags()});
      end
      rst_n = 1'b1;
      seen  = 0;
      for (int i = 0; i < W + 4; i++) begin
         tick();
         if (bus.done || bus.busy) seen++;
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_no_done: %0d busy/done cycles required 0", seen);
      end
      run_op(8'h33, 8'hC3, lat, bc);
      n_checks++;
      if (lat !== W || flags() !== model(8'h33, 8'hC3)) begin
         n_fail++;
         $display("FAIL reset_mid_fresh: latency %0d flags %b required latency %0d flags %b",
                  lat, flags(), W, model(8'h33, 8'hC3));
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_basic();
      test_signedness();
      test_random();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
